// File: rtl/gate_result_logger_if.sv
// Gate result logger bus: gate-stage sample inputs, record stream and overflow status.
// master = logger side, slave = producer/consumer side.
interface gate_result_logger_if #(
    parameter int TS_W   = 16,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              i;
    logic              m;
    logic              rl;
    logic              r;
    logic              out_valid;
    logic              out_ready;
    logic [TS_W+3:0]   out_data;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
    logic              clr_ovf;

    modport master (
        input  in_valid, i, m, rl, r, out_ready, clr_ovf,
        output out_valid, out_data, fifo_level, overflow, drop_cnt
    );

    modport slave (
        output in_valid, i, m, rl, r, out_ready, clr_ovf,
        input  out_valid, out_data, fifo_level, overflow, drop_cnt
    );
endinterface

// File: rtl/gate_result_logger.sv
// Gate result logger: samples the gate-stage outputs every clock, turns each
// change into a {timestamp, vector} record and queues it in a small FIFO
// drained over valid/ready. Drops on a full FIFO are flagged and counted.
module gate_result_logger #(
    parameter int TS_W   = 16,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_result_logger_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int REC_W = TS_W + 4;

    logic [TS_W-1:0]   r_ts;
    logic [3:0]        r_prev;
    logic              r_have_prev;
    logic [REC_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    logic [3:0]        w_vec;
    logic              w_event;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    assign w_vec   = {bus.i, bus.m, bus.rl, bus.r};
    assign w_event = bus.in_valid && (!r_have_prev || (w_vec != r_prev));
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_pop   = (r_level != '0) && bus.out_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    assign bus.out_valid  = (r_level != '0);
    assign bus.out_data   = r_mem[r_rptr];
    assign bus.fifo_level = r_level;
    assign bus.overflow   = r_overflow;
    assign bus.drop_cnt   = r_drop_cnt;

    // Free-running timestamp, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Remember the last valid sample; updated even when its record is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
        end else if (bus.in_valid) begin
            r_prev      <= w_vec;
            r_have_prev <= 1'b1;
        end
    end

    // Record storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= {r_ts, w_vec};
        end
    end

    // Read/write pointers (wrap naturally, DEPTH is a power of two) and fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Sticky overflow and saturating drop count; a drop coinciding with a clear wins as the first new drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (bus.clr_ovf) begin
                r_drop_cnt <= DROP_W'(1);
            end else if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_gate_result_logger.sv
// Testbench for gate_result_logger: queue-based scoreboard of expected records
// plus a small model of level, overflow and drop count, checked every cycle.
module tb_gate_result_logger;
    localparam int TS_W   = 4;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    gate_result_logger_if #(.TS_W(TS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    gate_result_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [TS_W+3:0]   exp_q[$];
    logic [TS_W-1:0]   m_ts;
    logic [3:0]        m_prev;
    logic              m_have;
    logic              m_ovf;
    logic [DROP_W-1:0] m_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ts   = '0;
        m_prev = '0;
        m_have = 1'b0;
        m_ovf  = 1'b0;
        m_cnt  = '0;
    endtask

    task automatic check_state(input string tag);
        check_val({tag, " level"}, 32'(bus.fifo_level), 32'(exp_q.size()));
        check_val({tag, " out_valid"}, 32'(bus.out_valid), 32'(exp_q.size() != 0));
        check_val({tag, " overflow"}, 32'(bus.overflow), 32'(m_ovf));
        check_val({tag, " drop_cnt"}, 32'(bus.drop_cnt), 32'(m_cnt));
        if (exp_q.size() != 0) begin
            check_val({tag, " head"}, 32'(bus.out_data), 32'(exp_q[0]));
        end
    endtask

    // Called at a negedge: drive inputs, advance the model for the coming posedge, check at the next negedge.
    task automatic cycle(input string tag, input logic iv, input logic [3:0] vec,
                         input logic rdy, input logic clr);
        logic pop, ev, full, drop;
        bus.in_valid  = iv;
        bus.i         = vec[3];
        bus.m         = vec[2];
        bus.rl        = vec[1];
        bus.r         = vec[0];
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;

        pop  = rdy && (exp_q.size() != 0);
        ev   = iv && (!m_have || (vec != m_prev));
        full = (exp_q.size() == DEPTH);
        drop = ev && full && !pop;
        if (pop) begin
            void'(exp_q.pop_front());
        end
        if (ev && !drop) begin
            exp_q.push_back({m_ts, vec});
        end
        if (drop) begin
            m_ovf = 1'b1;
            if (clr) m_cnt = 1;
            else if (m_cnt != {DROP_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = '0;
        end
        if (iv) begin
            m_prev = vec;
            m_have = 1'b1;
        end
        m_ts = m_ts + 1'b1;

        @(negedge clk);
        check_state(tag);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < DEPTH + 2; k++) begin
            cycle(tag, 1'b0, 4'h0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        logic [3:0] va, vb, vlast;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.i         = 1'b0;
        bus.m         = 1'b0;
        bus.rl        = 1'b0;
        bus.r         = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        model_reset();
        #1;
        check_val("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_val("reset out_data", 32'(bus.out_data), 32'd0);
        check_val("reset level", 32'(bus.fifo_level), 32'd0);
        check_val("reset overflow", 32'(bus.overflow), 32'd0);
        check_val("reset drop_cnt", 32'(bus.drop_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: nothing queued; ts advances (shows up in the next record).
        for (int k = 0; k < 10; k++) cycle("idle", 1'b0, 4'h0, 1'b0, 1'b0);

        // Change detection: two records, ts of first sample and first+3.
        for (int k = 0; k < 3; k++) cycle("chg", 1'b1, 4'b0101, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) cycle("chg", 1'b1, 4'b1011, 1'b1, 1'b0);
        drain("chg drain");

        // Backpressure: four stored, fifth dropped, head stable while stalled.
        for (int k = 1; k <= 5; k++) cycle("bp", 1'b1, 4'(k), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle("bp hold", 1'b0, 4'h0, 1'b0, 1'b0);
        check_val("bp head", 32'(bus.out_data[3:0]), 32'h1);
        drain("bp drain");

        // Clear on an idle cycle.
        cycle("clr idle", 1'b0, 4'h0, 1'b0, 1'b1);

        // Full with simultaneous pop and push.
        for (int k = 6; k <= 9; k++) cycle("fpp fill", 1'b1, 4'(k), 1'b0, 1'b0);
        cycle("fpp", 1'b1, 4'hA, 1'b1, 1'b0);
        check_val("fpp level", 32'(bus.fifo_level), 32'd4);
        check_val("fpp overflow", 32'(bus.overflow), 32'd0);
        drain("fpp drain");

        // Clear racing a drop, then idle clear, then saturation.
        for (int k = 11; k <= 14; k++) cycle("race fill", 1'b1, 4'(k), 1'b0, 1'b0);
        cycle("race", 1'b1, 4'hF, 1'b0, 1'b1);
        check_val("race drop_cnt", 32'(bus.drop_cnt), 32'd1);
        cycle("race clr", 1'b0, 4'h0, 1'b0, 1'b1);
        check_val("race clr overflow", 32'(bus.overflow), 32'd0);
        for (int k = 0; k < 270; k++) cycle("sat", 1'b1, (k % 2 == 0) ? 4'h5 : 4'hA, 1'b0, 1'b0);
        check_val("sat drop_cnt", 32'(bus.drop_cnt), 32'd255);
        drain("sat drain");
        cycle("sat clr", 1'b0, 4'h0, 1'b0, 1'b1);

        // Timestamp wrap: events sampled at ts 15 and ts 0.
        while (m_ts != 4'hF) cycle("wrap idle", 1'b0, 4'h0, 1'b0, 1'b0);
        va = m_prev ^ 4'h1;
        vb = va ^ 4'h2;
        cycle("wrap a", 1'b1, va, 1'b0, 1'b0);
        cycle("wrap b", 1'b1, vb, 1'b0, 1'b0);
        check_val("wrap ts15", 32'(bus.out_data[TS_W+3:4]), 32'hF);
        cycle("wrap pop", 1'b0, 4'h0, 1'b1, 1'b0);
        check_val("wrap ts0", 32'(bus.out_data[TS_W+3:4]), 32'h0);
        drain("wrap drain");

        // Mid-run reset with three records queued.
        for (int k = 1; k <= 3; k++) cycle("mr fill", 1'b1, 4'(k + 8), 1'b0, 1'b0);
        vlast = 4'hB;
        #2 rst_n = 1'b0;
        #1;
        check_val("mr out_valid", 32'(bus.out_valid), 32'd0);
        check_val("mr level", 32'(bus.fifo_level), 32'd0);
        check_val("mr out_data", 32'(bus.out_data), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle("mr first", 1'b1, vlast, 1'b0, 1'b0);
        check_val("mr first level", 32'(bus.fifo_level), 32'd1);
        drain("mr drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gate_result_logger.md
Name: gate_result_logger

Overview:
- Downstream consumer of the and/not/and/or gate stage: samples its four outputs (i, m, rl, r) every clock and detects changes.
- Each change becomes a timestamped record in a small FIFO, drained over a valid/ready interface.
- Gives the gate block a synthesizable, clocked result capture path, replacing reliance on simulator $monitor.

Parameters:
TS_W, 16, timestamp counter width in bits (>=4)
DEPTH, 4, FIFO depth in records (power of 2, >=2)
DROP_W, 8, width of saturating drop counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  gate outputs are meaningful this cycle
i  input  1  gate stage AND output
m  input  1  gate stage NOT output
rl  input  1  gate stage second AND output
r  input  1  gate stage OR output
out_valid  output  1  record available at FIFO head
out_ready  input  1  consumer accepts head record
out_data  output  TS_W+4  record {ts[TS_W-1:0], i, m, rl, r}; vector in LSBs, i at bit 3
fifo_level  output  clog2(DEPTH)+1  records currently stored
overflow  output  1  sticky: at least one record dropped
drop_cnt  output  DROP_W  saturating count of dropped records
clr_ovf  input  1  synchronous clear of overflow and drop_cnt

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, fifo_level=0, overflow=0, drop_cnt=0, ts=0, prev=0, have_prev=0, FIFO pointers=0. All outputs take these values immediately on assertion, not at the next edge.
- Timestamp: ts increments by 1 every clock after reset release. Wraps from 2^TS_W-1 to 0 with no flag.
- Sampling:
  - vec={i,m,rl,r}.
  - Event when in_valid=1 AND (have_prev=0 OR vec!=prev).
  - When in_valid=1: prev<=vec and have_prev<=1.
  - When in_valid=0: no event; prev and have_prev hold.
  - Record = {ts value in the sampling cycle, vec}.
- FIFO:
  - Registered storage. A record pushed at edge N is visible on out_valid/out_data after edge N, i.e. one cycle latency. No combinational bypass.
  - out_valid = (fifo_level != 0). out_data = head record; holds stable while out_valid=1 and out_ready=0.
  - out_data is a don't-care when out_valid=0, except after reset, when it is 0.
  - Pop occurs when out_valid && out_ready. out_ready with an empty FIFO has no effect.
  - Push occurs when event && (not full OR pop in the same cycle).
  - Full + pop + event: both happen and the level stays at DEPTH.
  - Empty + event: level becomes 1; out_valid rises next cycle.
  - Pointers wrap modulo DEPTH. fifo_level tracks 0..DEPTH exactly.
- Overflow:
  - Drop condition: event while full and no pop in that cycle. The record is discarded, overflow<=1, and drop_cnt increments, saturating at 2^DROP_W-1.
  - The sample is still recorded into prev even when its record is dropped.
  - clr_ovf=1 clears overflow and drop_cnt. If clr_ovf and a drop occur in the same cycle, the result is overflow=1, drop_cnt=1.
- Reset mid-operation: all FIFO contents are discarded. The first valid sample after release always produces an event.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release, in_valid=0 for 10 cycles -> out_valid=0, fifo_level=0, overflow=0, ts counts 0..10.
- Change detection: in_valid=1 with vec 4'b0101 for 3 cycles, then 4'b1011 for 2 cycles, out_ready=1 -> exactly 2 records: vec 0101 with ts of its first sample cycle, then vec 1011 with ts of first-sample+3. Each out_valid appears 1 cycle after its event.
- Backpressure/full: out_ready=0; apply 5 distinct vecs 0001,0010,0011,0100,0101 on consecutive cycles (DEPTH=4) -> fifo_level=4, overflow=1, drop_cnt=1. Head stays 0001 stable; draining yields 0001,0010,0011,0100.
- Full with simultaneous pop and push: FIFO full, out_ready=1, new event -> fifo_level stays 4, overflow stays 0, new record at tail.
- Overflow clear race: full, out_ready=0; pulse clr_ovf in the same cycle as a dropping event -> overflow=1, drop_cnt=1. Clear on an idle cycle -> overflow=0, drop_cnt=0. 256+ drops with DROP_W=8 -> drop_cnt saturates at 255.
- Timestamp wrap and mid-run reset: TS_W=4; events at ts=15 and ts=0 -> records carry ts 4'hF then 4'h0. Assert rst_n with 3 records queued -> out_valid=0 immediately. After release, first valid sample produces a record even if vec equals the pre-reset value.
